// File: rtl/sha256core_sched.sv
// sha256core_sched: sequence timing generator and round-robin block loader for
// one or more lock-stepped sha256core instances.
//
// Ports
//   CLK, RST          clock; asynchronous active-high reset
//   start             high on sequence cycles 0 and 1
//   ctx_num           sequence cycle bit 0
//   seq_num           toggles at every sequence wrap
//   core_ready[3:0]   free input slots of the core, index {ctx,seq}
//   req[N_REQ]        source i holds a complete block
//   req_blk_op        per-source block op, slice i
//   req_din           per-source FWFT data word, slice i
//   rd[N_REQ]         word-consumed strobe to the granted source
//   gnt[N_REQ]        one-cycle pulse at load start
//   wr_en/din/wr_addr core write port
//   input_ctx/seq     target slot of the current load
//   input_blk_op      op of the current load
//   set_input_ready   high with the 16th word only
//   busy              a load (or its trailing gap) is in progress
module sha256core_sched #(
  parameter int SEQ_CYCLES = 144,
  parameter int N_REQ      = 2,
  parameter int BLK_OP_MSB = 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  output logic                              start,
  output logic                              ctx_num,
  output logic                              seq_num,
  input  logic [3:0]                        core_ready,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ*(BLK_OP_MSB+1)-1:0]   req_blk_op,
  input  logic [N_REQ*32-1:0]               req_din,
  output logic [N_REQ-1:0]                  rd,
  output logic [N_REQ-1:0]                  gnt,
  output logic                              wr_en,
  output logic [31:0]                       din,
  output logic [3:0]                        wr_addr,
  output logic                              input_ctx,
  output logic                              input_seq,
  output logic [BLK_OP_MSB:0]               input_blk_op,
  output logic                              set_input_ready,
  output logic                              busy
);
  localparam int CNT_W = $clog2(SEQ_CYCLES);
  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int OP_W  = BLK_OP_MSB + 1;

  typedef enum logic [1:0] {IDLE, LOAD, GAP} state_t;

  logic [N_REQ-1:0][31:0]   src_din;
  logic [N_REQ-1:0][OP_W-1:0] src_op;
  assign src_din = req_din;
  assign src_op  = req_blk_op;

  // ---------------- sequencer ----------------
  logic [CNT_W-1:0] seq_cnt, cnt_nxt;
  assign cnt_nxt = (seq_cnt == CNT_W'(SEQ_CYCLES-1)) ? '0 : seq_cnt + 1'b1;

  // Outputs are computed from the next count so they line up with seq_cnt.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seq_cnt <= '0;
      start   <= 1'b1;
      ctx_num <= 1'b0;
      seq_num <= 1'b0;
    end else begin
      seq_cnt <= cnt_nxt;
      start   <= (cnt_nxt < CNT_W'(2));
      ctx_num <= cnt_nxt[0];
      if (cnt_nxt == '0) seq_num <= ~seq_num;
    end
  end

  // ---------------- loader ----------------
  state_t           state, state_nxt;
  logic [3:0]       word_cnt;
  logic [SEL_W-1:0] sel, last_gnt, pick;
  logic [1:0]       slot_q, slot_pick;
  logic [OP_W-1:0]  op_q;
  logic             go;

  // Round-robin: first requester strictly after last_gnt, wrapping.
  always_comb begin
    int idx;
    logic found;
    pick  = last_gnt;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_gnt) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
  end

  // Lowest-index free slot.
  always_comb begin
    slot_pick = 2'd3;
    for (int s = 3; s >= 0; s--)
      if (core_ready[s]) slot_pick = 2'(s);
  end

  assign go = (|req) && (|core_ready);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = LOAD;
      LOAD:    if (word_cnt == 4'd15) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_cnt <= '0;
      sel      <= '0;
      last_gnt <= SEL_W'(N_REQ-1);
      slot_q   <= '0;
      op_q     <= '0;
    end else if (state == IDLE) begin
      word_cnt <= '0;
      if (go) begin
        sel      <= pick;
        last_gnt <= pick;
        slot_q   <= slot_pick;
        op_q     <= src_op[pick];
      end
    end else if (state == LOAD) begin
      word_cnt <= word_cnt + 4'd1;
    end
  end

  // Write-side outputs decode straight from state so an async reset
  // silences them in the same cycle.
  always_comb begin
    rd              = '0;
    gnt             = '0;
    wr_en           = 1'b0;
    din             = '0;
    wr_addr         = '0;
    set_input_ready = 1'b0;
    if (state == LOAD) begin
      wr_en           = 1'b1;
      din             = src_din[sel];
      wr_addr         = word_cnt;
      rd[sel]         = 1'b1;
      gnt[sel]        = (word_cnt == 4'd0);
      set_input_ready = (word_cnt == 4'd15);
    end
  end

  assign busy         = (state != IDLE);
  assign input_ctx    = slot_q[1];
  assign input_seq    = slot_q[0];
  assign input_blk_op = op_q;

endmodule

// File: tb/tb_sha256core_sched.sv
module tb_sha256core_sched;
  localparam int SEQ = 144;
  localparam int NR  = 2;
  localparam int OPM = 1;

  logic CLK = 0;
  logic RST = 1;
  always #5 CLK = ~CLK;

  logic                    start, ctx_num, seq_num;
  logic [3:0]              core_ready;
  logic [NR-1:0]           req;
  logic [NR-1:0][OPM:0]    op_arr;
  logic [NR-1:0][31:0]     din_arr;
  logic [NR-1:0]           rd, gnt;
  logic                    wr_en;
  logic [31:0]             din;
  logic [3:0]              wr_addr;
  logic                    input_ctx, input_seq;
  logic [OPM:0]            input_blk_op;
  logic                    set_input_ready, busy;

  sha256core_sched #(.SEQ_CYCLES(SEQ), .N_REQ(NR), .BLK_OP_MSB(OPM)) dut (
    .CLK(CLK), .RST(RST), .start(start), .ctx_num(ctx_num), .seq_num(seq_num),
    .core_ready(core_ready), .req(req), .req_blk_op(op_arr), .req_din(din_arr),
    .rd(rd), .gnt(gnt), .wr_en(wr_en), .din(din), .wr_addr(wr_addr),
    .input_ctx(input_ctx), .input_seq(input_seq), .input_blk_op(input_blk_op),
    .set_input_ready(set_input_ready), .busy(busy)
  );

  typedef struct packed {
    logic [OPM:0]       op;
    logic [15:0][31:0]  w;
  } blk_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  src;
    logic [1:0]  slot;
    blk_t        b;
  } exp_t;

  blk_t  srcq[NR][$];
  int    widx[NR];
  exp_t  exp_q[$];
  exp_t  cur_e;
  int    cur = -1;
  int    mbusy = 0;
  int    mlast = NR-1;
  int    tcnt = 0;
  int    vectors = 0;
  int    miscompares = 0;
  logic [NR-1:0] en = '0;
  logic          rdy_mode = 1'b0;
  logic [3:0]    rdy_val = 4'b1111;

  // cycle index since reset release: cycle 0 is the one right after release
  always @(posedge CLK) tcnt <= RST ? 0 : tcnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (srcq[i].size() > 0) begin
        req[i]     = 1'b1;
        din_arr[i] = srcq[i][0].w[widx[i]];
        op_arr[i]  = srcq[i][0].op;
      end else begin
        req[i]     = 1'b0;
        din_arr[i] = '0;
        op_arr[i]  = '0;
      end
    end
    core_ready = rdy_mode ? 4'($urandom_range(0, 15)) : rdy_val;
  endtask

  // Reference: when idle, a present block and a free slot produce a grant
  // next cycle; the load then occupies 16 write cycles plus one gap.
  task automatic model_eval();
    int   c;
    int   pk;
    int   sl;
    exp_t e;
    if (mbusy > 0) begin
      mbusy--;
    end else if (core_ready != 4'b0) begin
      pk = -1;
      for (int j = 1; j <= NR; j++) begin
        c = (mlast + j) % NR;
        if (pk < 0 && srcq[c].size() > 0) pk = c;
      end
      if (pk >= 0) begin
        sl = 3;
        for (int s = 3; s >= 0; s--) if (core_ready[s]) sl = s;
        e.cyc  = 32'(tcnt + 1);
        e.src  = 8'(pk);
        e.slot = 2'(sl);
        e.b    = srcq[pk][0];
        exp_q.push_back(e);
        mlast = pk;
        mbusy = 17;
      end
    end
  endtask

  task automatic step(input bit arm, output bit hit);
    logic [NR-1:0] rd_q;
    blk_t b;
    hit = 0;
    @(negedge CLK);
    rd_q = rd;
    if (arm && wr_en && wr_addr == 4'd7) begin
      #2 RST = 1'b1;
      #1;
      chk("rst_async_outs", {wr_en, rd, busy, set_input_ready, gnt}, '0);
      chk("rst_async_start", start, 1);
      hit = 1;
    end
    if (!RST) model_eval();
    @(posedge CLK);
    #1;
    if (!RST) begin
      for (int i = 0; i < NR; i++) begin
        if (rd_q[i] && srcq[i].size() > 0) begin
          widx[i]++;
          if (widx[i] == 16) begin
            void'(srcq[i].pop_front());
            widx[i] = 0;
          end
        end
        if (en[i] && srcq[i].size() < 2 && $urandom_range(0, 3) == 0) begin
          b.op = (OPM+1)'($urandom);
          for (int k = 0; k < 16; k++) b.w[k] = $urandom;
          srcq[i].push_back(b);
        end
      end
    end
    drive();
  endtask

  // Monitor: compares every cycle against the scoreboard.
  always @(negedge CLK) begin
    if (RST) begin
      cur = -1;
      chk("rst_outs", {wr_en, rd, gnt, set_input_ready, busy, din, wr_addr}, '0);
      chk("rst_seq", {start, ctx_num, seq_num}, 3'b100);
    end else begin
      chk("start", start, ((tcnt % SEQ) < 2) ? 1 : 0);
      chk("ctx_num", ctx_num, tcnt % 2);
      chk("seq_num", seq_num, (tcnt / SEQ) % 2);
      if (gnt != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", gnt, 0);
        end else begin
          cur_e = exp_q.pop_front();
          chk("gnt_cycle", tcnt, cur_e.cyc);
          chk("gnt_onehot", gnt, 64'(1) << cur_e.src);
          chk("slot", {input_ctx, input_seq}, cur_e.slot);
          cur = 0;
        end
      end
      if (cur >= 0) begin
        chk("wr_en", wr_en, 1);
        chk("wr_addr", wr_addr, cur);
        chk("din", din, cur_e.b.w[cur]);
        chk("rd", rd, 64'(1) << cur_e.src);
        chk("set_input_ready", set_input_ready, (cur == 15) ? 1 : 0);
        if (cur == 15) chk("input_blk_op", input_blk_op, cur_e.b.op);
        cur++;
        if (cur == 16) cur = -1;
      end else begin
        chk("idle_quiet", {wr_en, rd, set_input_ready}, '0);
      end
    end
  end

  initial begin
    bit hit;
    hit = 0;
    for (int i = 0; i < NR; i++) widx[i] = 0;
    drive();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    en = 2'b01; rdy_mode = 0; rdy_val = 4'b1111;
    repeat (200) step(0, hit);
    en = 2'b11;
    repeat (300) step(0, hit);
    rdy_val = 4'b1100;
    repeat (100) step(0, hit);
    rdy_mode = 1;
    repeat (400) step(0, hit);
    rdy_mode = 0; rdy_val = 4'b0000;
    repeat (50) step(0, hit);
    rdy_val = 4'b1000;
    repeat (40) step(0, hit);

    // reset in the middle of a load
    rdy_val = 4'b1111;
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) step(1, hit);
    if (!hit) chk("rst_trigger_timeout", 0, 1);
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < NR; i++) begin
      srcq[i].delete();
      widx[i] = 0;
    end
    exp_q.delete();
    mbusy = 0;
    mlast = NR-1;
    drive();
    RST = 1'b0;

    repeat (300) step(0, hit);
    en = '0;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && mbusy == 0 && cur < 0 &&
          srcq[0].size() == 0 && srcq[1].size() == 0) break;
      step(0, hit);
    end
    chk("drain_pending", exp_q.size() + srcq[0].size() + srcq[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
